acc_cmd_sequencer: RTL and testbench

ACC_CMD_SEQUENCER -- requirements
Module: acc_cmd_sequencer

---
 rtl/acc_cmd_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_acc_cmd_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cmd_sequencer.sv
// acc_cmd_sequencer: turns one command (optional parameter writes A/B plus a
// control write) into a timed register-bus sequence toward an accelerator.
// It then waits for the busy pulse, reads back register 0 and returns a
// response carrying the status word, the busy length and a timeout flag.
//
// Handshakes (valid/ready):
//   cmd: a transfer happens on a rising edge where cmd_valid && cmd_ready.
//        cmd_ready is high only in IDLE while reset is released, so the
//        cmd_* fields are sampled exactly once per command.
//   rsp: rsp_valid rises on entry to RESP and stays high with all rsp_*
//        fields stable until a rising edge with rsp_valid && rsp_ready.
//        cmd_ready returns one cycle later, never in the handshake cycle.
module acc_cmd_sequencer #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 3,
  parameter int BUSY_TIMEOUT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_pa_en,
  input  logic                  cmd_pb_en,
  input  logic [REG_ADDR_W-1:0] cmd_pa_idx,
  input  logic [REG_ADDR_W-1:0] cmd_pb_idx,
  input  logic [DATA_W-1:0]     cmd_pa_data,
  input  logic [DATA_W-1:0]     cmd_pb_data,
  input  logic [DATA_W-1:0]     cmd_ctrl,
  // accelerator register bus
  output logic [REG_ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0]     cpu_data_out,
  output logic                  cpu_write,
  output logic                  cpu_read,
  input  logic [DATA_W-1:0]     cpu_data_in,
  input  logic                  cpu_acc_busy,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_status,
  output logic [CNT_W-1:0]      rsp_cycles,
  output logic                  rsp_timeout,
  // current FSM state, for debug and assertion binding
  output logic [3:0]            dbg_state
);

  // Timeout counter only has to reach BUSY_TIMEOUT-1.
  localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A,
    S_GAP_A,
    S_WR_B,
    S_GAP_B,
    S_WR_CTRL,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_RD,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;

  // registered copy of the accepted command
  logic                  r_pa_en;
  logic                  r_pb_en;
  logic [REG_ADDR_W-1:0] r_pa_idx;
  logic [REG_ADDR_W-1:0] r_pb_idx;
  logic [DATA_W-1:0]     r_pa_data;
  logic [DATA_W-1:0]     r_pb_data;
  logic [DATA_W-1:0]     r_ctrl;

  // wait-phase bookkeeping and response registers
  logic [TO_W-1:0]       r_to_cnt;
  logic [CNT_W-1:0]      r_busy_cnt;
  logic                  r_timeout;
  logic [DATA_W-1:0]     r_status;

  logic                  w_accept;
  logic                  w_to_expired;

  assign w_accept     = cmd_valid && cmd_ready;
  assign w_to_expired = (r_to_cnt == TO_LAST);

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and the register-bus strobes, which are pure
  // functions of the state so they vanish the instant reset asserts.
  always_comb begin
    w_next       = r_state;
    cpu_write    = 1'b0;
    cpu_read     = 1'b0;
    cpu_addr     = '0;
    cpu_data_out = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_pa_en)      w_next = S_WR_A;
          else if (cmd_pb_en) w_next = S_WR_B;
          else                w_next = S_WR_CTRL;
        end
      end
      S_WR_A: begin
        cpu_write    = 1'b1;
        cpu_addr     = r_pa_idx;
        cpu_data_out = r_pa_data;
        w_next       = S_GAP_A;
      end
      S_GAP_A: begin
        w_next = r_pb_en ? S_WR_B : S_WR_CTRL;
      end
      S_WR_B: begin
        cpu_write    = 1'b1;
        cpu_addr     = r_pb_idx;
        cpu_data_out = r_pb_data;
        w_next       = S_GAP_B;
      end
      S_GAP_B: begin
        w_next = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        cpu_write    = 1'b1;
        cpu_addr     = '0;
        cpu_data_out = r_ctrl;
        w_next       = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        // busy wins over an expiring timeout in the same cycle
        if (cpu_acc_busy)      w_next = S_WAIT_FALL;
        else if (w_to_expired) w_next = S_RD;
      end
      S_WAIT_FALL: begin
        if (!cpu_acc_busy) w_next = S_RD;
      end
      S_RD: begin
        cpu_read = 1'b1;
        cpu_addr = '0;
        w_next   = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Capture every command field on acceptance so inputs may change afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pa_en   <= 1'b0;
      r_pb_en   <= 1'b0;
      r_pa_idx  <= '0;
      r_pb_idx  <= '0;
      r_pa_data <= '0;
      r_pb_data <= '0;
      r_ctrl    <= '0;
    end else if (w_accept) begin
      r_pa_en   <= cmd_pa_en;
      r_pb_en   <= cmd_pb_en;
      r_pa_idx  <= cmd_pa_idx;
      r_pb_idx  <= cmd_pb_idx;
      r_pa_data <= cmd_pa_data;
      r_pb_data <= cmd_pb_data;
      r_ctrl    <= cmd_ctrl;
    end
  end

  // Timeout counter, busy-length counter and timeout flag for the wait phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt   <= '0;
      r_busy_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      unique case (r_state)
        S_WR_CTRL: begin
          r_to_cnt   <= '0;
          r_busy_cnt <= '0;
          r_timeout  <= 1'b0;
        end
        S_WAIT_RISE: begin
          if (cpu_acc_busy) begin
            // the rising cycle itself is the first busy cycle
            r_busy_cnt <= CNT_W'(1);
          end else if (w_to_expired) begin
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WAIT_FALL: begin
          if (cpu_acc_busy && (r_busy_cnt != {CNT_W{1'b1}})) begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read data arrives the cycle after the read strobe, i.e. in CAPTURE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_status <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_status <= cpu_data_in;
    end
  end

  assign cmd_ready   = (r_state == S_IDLE) && reset;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_status  = r_status;
  assign rsp_cycles  = r_busy_cnt;
  assign rsp_timeout = r_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_acc_cmd_sequencer.sv
// Bench for acc_cmd_sequencer: directed commands, a cycle-level expectation
// queue built from the sequencing rules, and a negedge compare process.
// A second instance with a 4-bit busy counter shares all inputs.
module tb_acc_cmd_sequencer;

  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int TO  = 4;
  localparam int CW  = 16;
  localparam int NCW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          cmd_valid, cmd_ready;
  logic          cmd_pa_en, cmd_pb_en;
  logic [AW-1:0] cmd_pa_idx, cmd_pb_idx;
  logic [DW-1:0] cmd_pa_data, cmd_pb_data, cmd_ctrl;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_out, cpu_data_in;
  logic          cpu_write, cpu_read, cpu_acc_busy;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_status;
  logic [CW-1:0] rsp_cycles;
  logic [3:0]    dbg_state;

  logic           n_cmd_ready, n_cpu_write, n_cpu_read, n_rsp_valid, n_rsp_timeout;
  logic [AW-1:0]  n_cpu_addr;
  logic [DW-1:0]  n_cpu_data_out, n_rsp_status;
  logic [NCW-1:0] n_rsp_cycles;
  logic [3:0]     n_dbg_state;

  acc_cmd_sequencer #(.DATA_W(DW), .REG_ADDR_W(AW), .BUSY_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pa_en(cmd_pa_en), .cmd_pb_en(cmd_pb_en),
    .cmd_pa_idx(cmd_pa_idx), .cmd_pb_idx(cmd_pb_idx),
    .cmd_pa_data(cmd_pa_data), .cmd_pb_data(cmd_pb_data), .cmd_ctrl(cmd_ctrl),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_data_in(cpu_data_in), .cpu_acc_busy(cpu_acc_busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout),
    .dbg_state(dbg_state)
  );

  acc_cmd_sequencer #(.DATA_W(DW), .REG_ADDR_W(AW), .BUSY_TIMEOUT(TO), .CNT_W(NCW)) dut_n (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready),
    .cmd_pa_en(cmd_pa_en), .cmd_pb_en(cmd_pb_en),
    .cmd_pa_idx(cmd_pa_idx), .cmd_pb_idx(cmd_pb_idx),
    .cmd_pa_data(cmd_pa_data), .cmd_pb_data(cmd_pb_data), .cmd_ctrl(cmd_ctrl),
    .cpu_addr(n_cpu_addr), .cpu_data_out(n_cpu_data_out),
    .cpu_write(n_cpu_write), .cpu_read(n_cpu_read),
    .cpu_data_in(cpu_data_in), .cpu_acc_busy(cpu_acc_busy),
    .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(n_rsp_status), .rsp_cycles(n_rsp_cycles), .rsp_timeout(n_rsp_timeout),
    .dbg_state(n_dbg_state)
  );

  // ---------------- scoreboard ----------------
  // One entry per cycle after acceptance: expected bus, cmd_ready, rsp_valid.
  typedef struct packed {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ready;
    logic          rv;
  } ent_t;

  ent_t exp_q[$];
  ent_t e;

  logic [DW-1:0]  exp_status;
  logic [CW-1:0]  exp_cycles;
  logic [NCW-1:0] exp_ncycles;
  logic           exp_timeout;

  int checks = 0;
  int errors = 0;

  // observations recorded for the literal pins
  int             cyc;
  int             rd_at;
  int             wr_cnt;
  logic [DW-1:0]  last_status;
  logic [CW-1:0]  last_cycles;
  logic [NCW-1:0] last_ncycles;
  logic           last_timeout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // compare process: one queue entry per cycle, sampled at the falling edge
  always @(negedge clk) begin
    cyc++;
    if (cpu_read && rd_at < 0) rd_at = cyc;
    if (cpu_write) wr_cnt++;
    if (rsp_valid) begin
      last_status  = rsp_status;
      last_cycles  = rsp_cycles;
      last_ncycles = n_rsp_cycles;
      last_timeout = rsp_timeout;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cpu_write", 64'(cpu_write), 64'(e.wr));
      check("cpu_read", 64'(cpu_read), 64'(e.rd));
      check("cpu_addr", 64'(cpu_addr), 64'(e.addr));
      check("cpu_data_out", 64'(cpu_data_out), 64'(e.data));
      check("cmd_ready", 64'(cmd_ready), 64'(e.ready));
      check("rsp_valid", 64'(rsp_valid), 64'(e.rv));
      check("n_cpu_write", 64'(n_cpu_write), 64'(e.wr));
      check("n_cpu_addr", 64'(n_cpu_addr), 64'(e.addr));
      check("n_rsp_valid", 64'(n_rsp_valid), 64'(e.rv));
      if (e.rv) begin
        check("rsp_status", 64'(rsp_status), 64'(exp_status));
        check("rsp_cycles", 64'(rsp_cycles), 64'(exp_cycles));
        check("rsp_timeout", 64'(rsp_timeout), 64'(exp_timeout));
        check("n_rsp_cycles", 64'(n_rsp_cycles), 64'(exp_ncycles));
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one command. d = WAIT_RISE cycles before busy rises, n = busy
  // length (0 = never), hold = cycles rsp_ready is held low, early = raise
  // cmd_valid during the rsp handshake cycle, abort_at = cycle to reset in.
  task automatic run_cmd(input logic pa_en, input logic [AW-1:0] pa_idx, input logic [DW-1:0] pa_data,
                         input logic pb_en, input logic [AW-1:0] pb_idx, input logic [DW-1:0] pb_data,
                         input logic [DW-1:0] ctrl, input int d, input int n,
                         input logic [DW-1:0] status, input int hold, input bit early, input int abort_at);
    int   len;
    int   ctrl_idx;
    int   cap_idx;
    bit   to;
    ent_t z;
    ent_t w;
    z = '0;
    cmd_pa_en = pa_en; cmd_pa_idx = pa_idx; cmd_pa_data = pa_data;
    cmd_pb_en = pb_en; cmd_pb_idx = pb_idx; cmd_pb_data = pb_data;
    cmd_ctrl = ctrl;
    cmd_valid = 1'b1;
    check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    // scramble the fields: the DUT must work from its registered copy
    cmd_pa_en = 1'($urandom_range(0, 1)); cmd_pb_en = 1'($urandom_range(0, 1));
    cmd_pa_idx = AW'($urandom_range(0, 7)); cmd_pb_idx = AW'($urandom_range(0, 7));
    cmd_pa_data = $urandom; cmd_pb_data = $urandom; cmd_ctrl = $urandom;
    cyc = 0; rd_at = -1; wr_cnt = 0;
    len = 0;
    if (pa_en) begin
      w = z; w.wr = 1'b1; w.addr = pa_idx; w.data = pa_data;
      exp_q.push_back(w); exp_q.push_back(z); len += 2;
    end
    if (pb_en) begin
      w = z; w.wr = 1'b1; w.addr = pb_idx; w.data = pb_data;
      exp_q.push_back(w); exp_q.push_back(z); len += 2;
    end
    w = z; w.wr = 1'b1; w.data = ctrl;
    exp_q.push_back(w); len++;
    ctrl_idx = len;
    to = (n == 0) || (d >= TO);
    if (!to) begin
      repeat (d + n + 1) begin exp_q.push_back(z); len++; end
      exp_cycles  = CW'(n);
      exp_ncycles = (n > 15) ? NCW'(15) : NCW'(n);
      exp_timeout = 1'b0;
    end else begin
      repeat (TO) begin exp_q.push_back(z); len++; end
      exp_cycles  = '0;
      exp_ncycles = '0;
      exp_timeout = 1'b1;
    end
    w = z; w.rd = 1'b1;
    exp_q.push_back(w); len++;
    exp_q.push_back(z); len++;
    cap_idx = len;
    w = z; w.rv = 1'b1;
    repeat (hold + 1) begin exp_q.push_back(w); len++; end
    w = z; w.ready = 1'b1;
    exp_q.push_back(w); len++;
    exp_status = status;
    for (int k = 1; k <= len; k++) begin
      cpu_acc_busy = !to && (k >= ctrl_idx + 1 + d) && (k <= ctrl_idx + d + n);
      cpu_data_in  = (k == cap_idx) ? status : ~status;
      rsp_ready    = (k == len - 1);
      cmd_valid    = early && (k == len - 1);
      if (k == abort_at) begin
        exp_q.delete();
        #2;
        reset = 1'b0;
        #1;
        check("abort_cpu_write", 64'(cpu_write), 64'd0);
        check("abort_cpu_read", 64'(cpu_read), 64'd0);
        check("abort_cpu_addr", 64'(cpu_addr), 64'd0);
        check("abort_cpu_data_out", 64'(cpu_data_out), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_rsp_status", 64'(rsp_status), 64'd0);
        check("abort_rsp_cycles", 64'(rsp_cycles), 64'd0);
        check("abort_rsp_timeout", 64'(rsp_timeout), 64'd0);
        repeat (2) begin
          @(negedge clk);
          check("abort_hold_write", 64'(cpu_write), 64'd0);
          check("abort_hold_read", 64'(cpu_read), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        cpu_acc_busy = 1'b0;
        #1;
        check("abort_release_ready", 64'(cmd_ready), 64'd1);
        check("abort_release_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("abort_no_strobe", 64'(cpu_write | cpu_read), 64'd0);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cpu_acc_busy = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_pa_en = 1'b0; cmd_pb_en = 1'b0;
    cmd_pa_idx = '0; cmd_pb_idx = '0; cmd_pa_data = '0; cmd_pb_data = '0; cmd_ctrl = '0;
    cpu_data_in = '0; cpu_acc_busy = 1'b0; rsp_ready = 1'b0;
    cyc = 0; rd_at = -1; wr_cnt = 0;
    last_status = '0; last_cycles = '0; last_ncycles = '0; last_timeout = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cpu_write", 64'(cpu_write), 64'd0);
    check("reset_cpu_read", 64'(cpu_read), 64'd0);
    check("reset_cpu_addr", 64'(cpu_addr), 64'd0);
    check("reset_cpu_data_out", 64'(cpu_data_out), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_status", 64'(rsp_status), 64'd0);
    check("reset_rsp_cycles", 64'(rsp_cycles), 64'd0);
    check("reset_rsp_timeout", 64'(rsp_timeout), 64'd0);
    reset = 1'b1;
    #1;
    check("reset_release_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;

    // load: reg2, gap, reg5, gap, reg0; busy 9 cycles
    run_cmd(1'b1, 3'd2, 32'h000, 1'b1, 3'd5, 32'h000, 32'h001, 0, 9, 32'h11, 0, 1'b0, 0);
    check("load_writes", 64'(wr_cnt), 64'd3);
    check("load_rd_cycle", 64'(rd_at), 64'd16);
    check("load_cycles_lit", 64'(last_cycles), 64'd9);
    check("load_timeout_lit", 64'(last_timeout), 64'd0);

    // sum: only reg7 then reg0
    run_cmd(1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 32'h020, 32'h4103, 2, 3, 32'h3, 1, 1'b0, 0);
    check("sum_writes", 64'(wr_cnt), 64'd2);
    check("sum_rd_cycle", 64'(rd_at), 64'd10);
    check("sum_cycles_lit", 64'(last_cycles), 64'd3);

    // config: busy never rises
    run_cmd(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h01C, 0, 0, 32'h1C5, 0, 1'b0, 0);
    check("config_rd_cycle", 64'(rd_at), 64'd6);
    check("config_timeout_lit", 64'(last_timeout), 64'd1);
    check("config_cycles_lit", 64'(last_cycles), 64'd0);

    // status: 0xA5 captured, response held 5 cycles, early cmd_valid refused
    run_cmd(1'b1, 3'd3, 32'hCAFE, 1'b0, 3'd0, 32'h0, 32'h77, 1, 2, 32'hA5, 5, 1'b1, 0);
    check("status_lit", 64'(last_status), 64'hA5);

    // busy rises exactly on the timeout-expiry cycle
    run_cmd(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h2, 3, 2, 32'h5A, 0, 1'b0, 0);
    check("glitch_timeout_lit", 64'(last_timeout), 64'd0);
    check("glitch_cycles_lit", 64'(last_cycles), 64'd2);

    // saturation: 20 busy cycles
    run_cmd(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h9, 0, 20, 32'h1, 2, 1'b0, 0);
    check("sat_narrow_lit", 64'(last_ncycles), 64'hF);
    check("sat_wide_lit", 64'(last_cycles), 64'd20);
    check("sat_rd_cycle", 64'(rd_at), 64'd23);

    // reset in WAIT_FALL, then a normal command
    run_cmd(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h5, 0, 15, 32'h7, 0, 1'b0, 6);
    run_cmd(1'b1, 3'd1, 32'h1234_5678, 1'b1, 3'd6, 32'h9ABC_DEF0, 32'h42, 0, 4, 32'hBEEF, 0, 1'b0, 0);
    check("post_reset_writes", 64'(wr_cnt), 64'd3);
    check("post_reset_status_lit", 64'(last_status), 64'hBEEF);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
